// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: shared FIFO mode constants and width helper
package sync_fifo_param_pkg;
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo_param_sdp_ram.sv
// sync_fifo_param_sdp_ram: simple dual-port RAM, synchronous write, registered read-first port
module sync_fifo_param_sdp_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with thresholds, occupancy, error pulses and
// standard or first-word-fall-through read mode
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 16,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);
    localparam bit          IS_FWFT  = (FWFT == FIFO_FWFT);

    logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr, ram_raddr;
    logic [AW:0]      count_nxt;
    logic [WIDTH-1:0] ram_q, byp_data;
    logic             rd_acc, wr_acc, byp_sel, loaded, valid_q;

    assign rd_acc    = rd_en & ~empty;
    assign wr_acc    = wr_en & (~full | rd_acc);
    assign rd_addr   = rd_ptr + AW'(rd_acc);
    // FWFT prefetches the post-pop head every cycle so it is on dout right after the edge
    assign ram_raddr = IS_FWFT ? rd_addr : rd_ptr;
    assign count_nxt = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

    sync_fifo_param_sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(din),
        .re   (IS_FWFT | rd_acc),
        .raddr(ram_raddr),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            valid_q      <= 1'b0;
            loaded       <= 1'b0;
            byp_sel      <= 1'b0;
            byp_data     <= '0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(wr_acc);
            rd_ptr       <= rd_addr;
            count        <= count_nxt;
            full         <= count_nxt == FULL_CNT;
            empty        <= count_nxt == '0;
            almost_full  <= count_nxt >= AF_CNT;
            almost_empty <= count_nxt <= AE_CNT;
            overflow     <= wr_en & ~wr_acc;
            underflow    <= rd_en & ~rd_acc;
            valid_q      <= rd_acc;
            loaded       <= loaded | rd_acc;
            // read-first RAM returns stale data when the head is written this edge
            byp_sel      <= wr_acc && (wr_ptr == ram_raddr);
            byp_data     <= din;
        end
    end

    always_comb begin
        valid = IS_FWFT ? ~empty : valid_q;
        dout  = IS_FWFT ? (empty ? '0 : (byp_sel ? byp_data : ram_q)) : (loaded ? ram_q : '0);
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of standard and FWFT builds driven in lockstep
module tb_sync_fifo_param;
    logic       clk, rst_n, wr_en, rd_en;
    logic [4:0] din;
    logic [4:0] s_dout, f_dout, s_count, f_count;
    logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    int         n_chk = 0, n_pass = 0;

    sync_fifo_param #(.WIDTH(5), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_param #(.WIDTH(5), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        #12;
        check("rst_s_count", int'(s_count), 0);
        check("rst_s_empty", int'(s_empty), 1);
        check("rst_s_full", int'(s_full), 0);
        check("rst_s_ae", int'(s_ae), 1);
        check("rst_s_af", int'(s_af), 0);
        check("rst_s_valid", int'(s_valid), 0);
        check("rst_s_dout", int'(s_dout), 0);
        check("rst_s_ovf", int'(s_ovf), 0);
        check("rst_s_udf", int'(s_udf), 0);
        check("rst_f_valid", int'(f_valid), 0);
        check("rst_f_empty", int'(f_empty), 1);
        rst_n = 1'b1;
        tick();
        // 1: fill with 0..15
        for (int i = 0; i < 16; i++) begin
            din = 5'(i); wr_en = 1'b1;
            tick();
            check("fill_s_count", int'(s_count), i + 1);
            check("fill_s_af", int'(s_af), int'(i + 1 >= 14));
            check("fill_s_ae", int'(s_ae), int'(i + 1 <= 2));
            check("fill_s_full", int'(s_full), int'(i == 15));
            check("fill_f_count", int'(f_count), i + 1);
            if (i == 0) begin
                check("fill_f_valid", int'(f_valid), 1);
                check("fill_f_dout", int'(f_dout), 0);
            end
        end
        // 2: overflow then drain
        din = 5'd16; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("ovf_s", int'(s_ovf), 1);
        check("ovf_f", int'(f_ovf), 1);
        check("ovf_s_count", int'(s_count), 16);
        tick();
        check("ovf_s_clear", int'(s_ovf), 0);
        rd_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("drain_f_dout", int'(f_dout), j);
            tick();
            check("drain_s_dout", int'(s_dout), j);
            check("drain_s_valid", int'(s_valid), 1);
            check("drain_s_count", int'(s_count), 15 - j);
        end
        rd_en = 1'b0;
        check("drain_s_empty", int'(s_empty), 1);
        check("drain_f_empty", int'(f_empty), 1);
        tick();
        check("idle_s_valid", int'(s_valid), 0);
        check("idle_s_hold", int'(s_dout), 15);
        // 3: single-word latency
        din = 5'd7; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("lat_f_dout", int'(f_dout), 7);
        check("lat_f_valid", int'(f_valid), 1);
        check("lat_s_valid", int'(s_valid), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("lat_s_dout", int'(s_dout), 7);
        check("lat_s_valid1", int'(s_valid), 1);
        check("lat_f_count", int'(f_count), 0);
        check("lat_f_valid0", int'(f_valid), 0);
        // 4: simultaneous read+write on full
        for (int i = 0; i < 16; i++) begin
            din = 5'(i); wr_en = 1'b1;
            tick();
        end
        din = 5'd21; rd_en = 1'b1;
        check("rw_f_head", int'(f_dout), 0);
        tick();
        wr_en = 1'b0;
        check("rw_s_ovf", int'(s_ovf), 0);
        check("rw_f_ovf", int'(f_ovf), 0);
        check("rw_s_count", int'(s_count), 16);
        check("rw_f_count", int'(f_count), 16);
        check("rw_s_dout", int'(s_dout), 0);
        for (int k = 0; k < 16; k++) begin
            check("rw_f_dout", int'(f_dout), k < 15 ? k + 1 : 21);
            tick();
            check("rw_s_dout", int'(s_dout), k < 15 ? k + 1 : 21);
        end
        rd_en = 1'b0;
        check("rw_s_empty", int'(s_empty), 1);
        check("rw_f_empty", int'(f_empty), 1);
        // 5: underflow with concurrent write
        din = 5'd3; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("udf_s", int'(s_udf), 1);
        check("udf_f", int'(f_udf), 1);
        check("udf_s_count", int'(s_count), 1);
        check("udf_f_count", int'(f_count), 1);
        check("udf_s_valid", int'(s_valid), 0);
        check("udf_f_dout", int'(f_dout), 3);
        tick();
        check("udf_s_clear", int'(s_udf), 0);
        check("udf_f_clear", int'(f_udf), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_s_dout", int'(s_dout), 3);
        check("udf_s_count0", int'(s_count), 0);
        // 6: reset mid-burst
        for (int i = 0; i < 5; i++) begin
            din = 5'(10 + i); wr_en = 1'b1;
            tick();
        end
        check("mid_s_count", int'(s_count), 5);
        #2 rst_n = 1'b0;
        #1;
        check("ar_s_count", int'(s_count), 0);
        check("ar_s_empty", int'(s_empty), 1);
        check("ar_s_dout", int'(s_dout), 0);
        check("ar_s_ae", int'(s_ae), 1);
        check("ar_f_count", int'(f_count), 0);
        check("ar_f_dout", int'(f_dout), 0);
        check("ar_f_valid", int'(f_valid), 0);
        wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        din = 5'd9; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("post_f_dout", int'(f_dout), 9);
        check("post_s_count", int'(s_count), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_s_dout", int'(s_dout), 9);
        check("post_s_valid", int'(s_valid), 1);
        check("post_s_empty", int'(s_empty), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
